game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 145 ++++++++++++++
 tb/tb_game_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game control sequencer: IDLE/PLAY/PAUSE/OVER FSM, obstacle-scroll timer with
// a per-difficulty ramping period, and the datapath clear pulse.
module game_sequencer #(
  parameter int T_INIT = 1_000_000,
  parameter int MIN0   = 500_000,
  parameter int MIN1   = 400_000,
  parameter int MIN2   = 400_000,
  parameter int MIN3   = 300_000,
  parameter int STEP0  = 100,
  parameter int STEP1  = 200,
  parameter int STEP2  = 500,
  parameter int STEP3  = 1000,
  parameter int LVL1   = 5,
  parameter int LVL2   = 10,
  parameter int LVL3   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       crash,
  input  logic [9:0] score,
  output logic       move,
  output logic       stop,
  output logic [1:0] easy,
  output logic [1:0] state,
  output logic       game_rst_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [20:0] T_INIT_W = 21'(T_INIT);
  localparam logic [9:0]  LVL1_W   = 10'(LVL1);
  localparam logic [9:0]  LVL2_W   = 10'(LVL2);
  localparam logic [9:0]  LVL3_W   = 10'(LVL3);

  state_t      cur, nxt;
  logic        start_q, pause_q;
  logic        start_edge, pause_edge;
  logic [20:0] cnt, period;
  logic [20:0] min_sel, step_sel, period_nxt;
  logic        launch, run, tick;
  logic        move_d, stop_d, rst_d;
  logic [1:0]  easy_d, lvl;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;
  assign state      = cur;

  // State register plus every registered output and the timer datapath.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur        <= IDLE;
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
      move       <= 1'b0;
      stop       <= 1'b1;
      easy       <= 2'd0;
      game_rst_n <= 1'b1;
      cnt        <= '0;
      period     <= T_INIT_W;
    end else begin
      cur        <= nxt;
      start_q    <= start;
      pause_q    <= pause;
      move       <= move_d;
      stop       <= stop_d;
      easy       <= easy_d;
      game_rst_n <= rst_d;
      if (launch) begin
        cnt    <= '0;
        period <= T_INIT_W;
      end else if (nxt == OVER && cur != OVER) begin
        cnt <= '0;
      end else if (tick) begin
        cnt    <= '0;
        period <= period_nxt;
      end else if (run) begin
        cnt <= cnt + 21'd1;
      end
    end
  end

  // Next-state logic; crash outranks pause, and IDLE only listens to start.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:  if (start_edge) nxt = PLAY;
      PLAY:  if (crash) nxt = OVER;
             else if (pause_edge) nxt = PAUSE;
      PAUSE: if (pause_edge) nxt = PLAY;
      OVER:  if (start_edge) nxt = PLAY;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    min_sel  = 21'(MIN0);
    step_sel = 21'(STEP0);
    case (easy)
      2'd1: begin min_sel = 21'(MIN1); step_sel = 21'(STEP1); end
      2'd2: begin min_sel = 21'(MIN2); step_sel = 21'(STEP2); end
      2'd3: begin min_sel = 21'(MIN3); step_sel = 21'(STEP3); end
      default: ;
    endcase
  end

  // Compare in 22 bits so period - step can never wrap below the floor.
  always_comb begin
    if ({1'b0, period} < ({1'b0, step_sel} + {1'b0, min_sel}))
      period_nxt = min_sel;
    else
      period_nxt = period - step_sel;
  end

  always_comb begin
    if (score < LVL1_W)      lvl = 2'd0;
    else if (score < LVL2_W) lvl = 2'd1;
    else if (score < LVL3_W) lvl = 2'd2;
    else                     lvl = 2'd3;
  end

  // Output logic. The timer only runs while PLAY persists, so a crash or pause
  // arriving with an expired count never leaks a move into OVER/PAUSE.
  always_comb begin
    launch = (cur == IDLE || cur == OVER) && nxt == PLAY;
    run    = cur == PLAY && nxt == PLAY;
    tick   = run && (cnt >= period);
    move_d = tick;
    stop_d = nxt != PLAY;
    rst_d  = !launch;
    easy_d = easy;
    case (cur)
      IDLE:        easy_d = 2'd0;
      PLAY, PAUSE: easy_d = lvl;
      default:     easy_d = easy;
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small timing parameters.
module tb_game_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       crash = 1'b0;
  logic [9:0] score = 10'd0;
  logic       move, stop, game_rst_n;
  logic [1:0] easy, state;

  int errors = 0;
  int checks = 0;

  game_sequencer #(
    .T_INIT(20),
    .MIN0(10), .MIN1(8), .MIN2(8), .MIN3(6),
    .STEP0(2), .STEP1(3), .STEP2(4), .STEP3(5),
    .LVL1(5), .LVL2(10), .LVL3(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .crash(crash),
    .score(score), .move(move), .stop(stop), .easy(easy), .state(state),
    .game_rst_n(game_rst_n)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Cycles until the next move pulse; returns limit+1 if none arrives.
  task automatic wait_move(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!move && n <= limit);
  endtask

  task automatic restart_game();
    crash = 1'b1; tick(); crash = 1'b0;
    start = 1'b0; tick(); start = 1'b1; tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(3);
    checks++; if (state !== 2'd0 || stop !== 1'b1 || move !== 1'b0 || easy !== 2'd0 || game_rst_n !== 1'b1) begin
      errors++; $display("FAIL reset_state: got state=%0d stop=%b move=%b easy=%0d rst_n=%b, need 0/1/0/0/1", state, stop, move, easy, game_rst_n);
    end
    reset = 1'b1; tick(2);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold: got state=%0d need 0", state); end
  endtask

  task automatic test_start_ramp();
    int n;
    int gaps[7] = '{20, 19, 17, 15, 13, 11, 11};
    start = 1'b1; tick();
    checks++; if (state !== 2'd1 || stop !== 1'b0 || game_rst_n !== 1'b0) begin
      errors++; $display("FAIL start_entry: got state=%0d stop=%b rst_n=%b, need 1/0/0", state, stop, game_rst_n);
    end
    tick();
    checks++; if (game_rst_n !== 1'b1) begin errors++; $display("FAIL rst_pulse_width: got rst_n=%b need 1", game_rst_n); end
    foreach (gaps[i]) begin
      wait_move(40, n);
      checks++; if (n !== gaps[i]) begin errors++; $display("FAIL ramp_gap%0d: got %0d need %0d", i, n, gaps[i]); end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    int moves = 0;
    int seen_pause = 0;
    crash = 1'b1; pause = 1'b1; tick();
    if (state == 2'd2) seen_pause++;
    checks++; if (state !== 2'd3 || stop !== 1'b1) begin
      errors++; $display("FAIL crash_priority: got state=%0d stop=%b need 3/1", state, stop);
    end
    crash = 1'b0; pause = 1'b0; tick();
    pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (move) moves++;
      if (state == 2'd2) seen_pause++;
    end
    pause = 1'b0;
    checks++; if (state !== 2'd3 || moves !== 0 || seen_pause !== 0) begin
      errors++; $display("FAIL over_hold: got state=%0d moves=%0d pause_visits=%0d need 3/0/0", state, moves, seen_pause);
    end
    start = 1'b0; tick(); start = 1'b1; tick();
    checks++; if (state !== 2'd1 || game_rst_n !== 1'b0) begin
      errors++; $display("FAIL over_restart: got state=%0d rst_n=%b need 1/0", state, game_rst_n);
    end
    tick();
    checks++; if (game_rst_n !== 1'b1) begin errors++; $display("FAIL over_rst_width: got rst_n=%b need 1", game_rst_n); end
    wait_move(40, n);
    checks++; if (n !== 20) begin errors++; $display("FAIL period_reload: got gap %0d need 20", n); end
  endtask

  task automatic test_pause();
    int n;
    int moves = 0;
    restart_game();
    tick(7);
    pause = 1'b1; tick();
    checks++; if (state !== 2'd2 || stop !== 1'b1) begin
      errors++; $display("FAIL pause_entry: got state=%0d stop=%b need 2/1", state, stop);
    end
    for (int i = 0; i < 30; i++) begin tick(); if (move) moves++; end
    checks++; if (moves !== 0 || state !== 2'd2) begin
      errors++; $display("FAIL pause_freeze: got moves=%0d state=%0d need 0/2", moves, state);
    end
    pause = 1'b0; tick(); pause = 1'b1; tick();
    checks++; if (state !== 2'd1 || stop !== 1'b0) begin
      errors++; $display("FAIL pause_resume: got state=%0d stop=%b need 1/0", state, stop);
    end
    wait_move(40, n);
    checks++; if (n !== 14) begin errors++; $display("FAIL pause_count_hold: got gap %0d need 14", n); end
    pause = 1'b0; tick();
  endtask

  task automatic test_levels();
    int n;
    int sc[4]  = '{4, 5, 10, 15};
    int lv[4]  = '{0, 1, 2, 3};
    int gap[5] = '{21, 18, 14, 10, 7};
    pause = 1'b1; tick();
    foreach (sc[i]) begin
      score = 10'(sc[i]); tick();
      checks++; if (easy !== 2'(lv[i])) begin errors++; $display("FAIL easy_score%0d: got %0d need %0d", sc[i], easy, lv[i]); end
    end
    pause = 1'b0; tick(); pause = 1'b1; tick(); pause = 1'b0;
    crash = 1'b1; tick(); crash = 1'b0;
    score = 10'd0; tick(3);
    checks++; if (state !== 2'd3 || easy !== 2'd3) begin
      errors++; $display("FAIL easy_over_hold: got state=%0d easy=%0d need 3/3", state, easy);
    end
    score = 10'd5;
    start = 1'b0; tick(); start = 1'b1; tick();
    foreach (gap[i]) begin
      wait_move(40, n);
      checks++; if (n !== gap[i]) begin errors++; $display("FAIL level_gap%0d: got %0d need %0d", i, n, gap[i]); end
      if (i == 0) score = 10'd10;
      if (i == 2) score = 10'd15;
    end
  endtask

  task automatic test_reset_keys_held();
    int bad = 0;
    start = 1'b1; pause = 1'b1; reset = 1'b0; tick(2);
    checks++; if (state !== 2'd0 || stop !== 1'b1 || move !== 1'b0 || easy !== 2'd0 || game_rst_n !== 1'b1) begin
      errors++; $display("FAIL midgame_reset: got state=%0d stop=%b move=%b easy=%0d rst_n=%b need 0/1/0/0/1", state, stop, move, easy, game_rst_n);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (state !== 2'd0 || move) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL held_keys: got %0d non-idle cycles need 0", bad); end
    start = 1'b0; pause = 1'b0; tick();
    start = 1'b1; pause = 1'b1; tick();
    checks++; if (state !== 2'd1 || stop !== 1'b0) begin
      errors++; $display("FAIL idle_start_pause: got state=%0d stop=%b need 1/0", state, stop);
    end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL idle_pause_ignored: got state=%0d need 1", state); end
  endtask

  initial begin
    test_reset();
    test_start_ramp();
    test_simultaneous();
    test_pause();
    test_levels();
    test_reset_keys_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
